// File: rtl/branch_cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_pkg : condition codes and FSM encoding shared by the
//                        branch-condition unit and its evaluator.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package branch_cond_unit_pkg;

    // A 2-bit field maps onto the low half of this table.
    localparam logic [2:0] CC_ZERO    = 3'b000;
    localparam logic [2:0] CC_NONZERO = 3'b001;
    localparam logic [2:0] CC_POS     = 3'b010;
    localparam logic [2:0] CC_NEG     = 3'b011;
    localparam logic [2:0] CC_ALWAYS  = 3'b100;
    localparam logic [2:0] CC_NEVER   = 3'b101;
    localparam logic [2:0] CC_GTZ     = 3'b110;
    localparam logic [2:0] CC_LEZ     = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

endpackage : branch_cond_unit_pkg

`default_nettype wire

// File: rtl/branch_cond_unit_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_cond_eval : combinational condition-code decoder,
//                              cc + operand -> taken.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module branch_cond_unit_cond_eval
    import branch_cond_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COND_W     = 2
) (
    input  logic [COND_W-1:0]     i_cc,
    input  logic [DATA_WIDTH-1:0] i_operand,
    output logic                  o_taken
);

    logic [2:0] w_cc;
    logic       w_zero;
    logic       w_neg;

    generate
        if (COND_W == 2) begin : g_cc2
            assign w_cc = {1'b0, i_cc};
        end else if (COND_W == 3) begin : g_cc3
            assign w_cc = i_cc;
        end else begin : g_bad_cond_w
            $error("branch_cond_unit: COND_W must be 2 or 3");
        end
    endgenerate

    assign w_zero = (i_operand == '0);
    assign w_neg  = i_operand[DATA_WIDTH-1];

    always_comb begin
        o_taken = 1'b0;
        case (w_cc)
            CC_ZERO:    o_taken = w_zero;
            CC_NONZERO: o_taken = ~w_zero;
            CC_POS:     o_taken = ~w_neg;
            CC_NEG:     o_taken = w_neg;
            CC_ALWAYS:  o_taken = 1'b1;
            CC_NEVER:   o_taken = 1'b0;
            CC_GTZ:     o_taken = ~w_neg & ~w_zero;
            CC_LEZ:     o_taken = w_neg | w_zero;
        endcase
    end

endmodule : branch_cond_unit_cond_eval

`default_nettype wire

// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit : registered branch-condition flag with valid/ack handshake
//                    and saturating taken-branch counter.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IR_WIDTH   = 32,
    parameter int COND_LSB   = 19,
    parameter int COND_W     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [IR_WIDTH-1:0]   ir,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  con_in,
    input  logic                  con_clr,
    input  logic                  con_ack,
    output logic                  con_out,
    output logic                  con_valid,
    output logic [CNT_WIDTH-1:0]  taken_cnt,
    input  logic                  cnt_clr
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_capture;
    logic                  w_taken;
    logic                  r_con_out;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_ir_unused;

    // Only the condition field of IR matters here.
    assign w_ir_unused = ^ir;

    branch_cond_unit_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH),
        .COND_W     (COND_W)
    ) u_cond_eval (
        .i_cc      (ir[COND_LSB +: COND_W]),
        .i_operand (bus_in),
        .o_taken   (w_taken)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (con_clr) begin
            w_state_nxt = ST_IDLE;
        end else if (con_in) begin
            w_state_nxt = ST_VALID;
            w_capture   = 1'b1;
        end else if ((r_state == ST_VALID) && con_ack) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= ST_IDLE;
            r_con_out <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (con_clr) begin
                r_con_out <= 1'b0;
            end else if (w_capture) begin
                r_con_out <= w_taken;
            end
        end
    end

    // Clear beats increment; a cleared capture never counts.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_capture && w_taken && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign con_out   = r_con_out;
    assign con_valid = (r_state == ST_VALID);
    assign taken_cnt = r_cnt;

endmodule : branch_cond_unit

`default_nettype wire

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
Parametrised successor to the datapath branch-condition flip-flop. It decodes the condition field of the instruction register, evaluates it against the bus value on a control-unit load strobe, and registers the result. The result is presented to the control unit through a valid/ack handshake. A saturating taken-branch counter feeds the debug/perf path. It sits between the bus mux output and the control unit, replacing the purely combinational condition path.

Parameters:
DATA_WIDTH, 32, width of bus operand evaluated
IR_WIDTH, 32, instruction register width
COND_LSB, 19, bit position of condition field LSB in IR
COND_W, 2, condition field width; legal values 2 or 3 (anything else is an elaboration error)
CNT_WIDTH, 16, taken-branch counter width

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
ir  in  IR_WIDTH  instruction register contents
bus_in  in  DATA_WIDTH  bus mux output (value under test)
con_in  in  1  load strobe: evaluate and capture this cycle
con_clr  in  1  synchronous clear of flag/valid
con_ack  in  1  control unit consumed result
con_out  out  1  registered branch-taken flag
con_valid  out  1  con_out holds an unconsumed result
taken_cnt  out  CNT_WIDTH  saturating count of taken evaluations
cnt_clr  in  1  synchronous clear of taken_cnt

Behaviour:
- Reset (clear_n=0, asynchronous): con_out=0, con_valid=0, taken_cnt=0, FSM=IDLE.
- Condition code cc = ir[COND_LSB+COND_W-1:COND_LSB]. Taken is computed combinationally, then registered.
- COND_W=2 codes: 00 zero (bus_in==0); 01 nonzero; 10 positive (bus_in[MSB]==0, zero counts as positive); 11 negative (bus_in[MSB]==1).
- COND_W=3 codes: 000–011 as above with a leading 0; 100 always; 101 never; 110 strictly positive (MSB==0 and bus_in!=0); 111 non-positive (MSB==1 or bus_in==0).
- Latency: con_in sampled high at edge N -> con_out and con_valid updated at edge N, visible in cycle N+1. No combinational path from bus_in to con_out.
- FSM states:
  - IDLE: con_valid=0. con_in -> VALID (capture taken).
  - VALID: con_valid=1. con_ack -> IDLE. con_in (with or without con_ack) -> stay VALID and recapture; the newer result wins.
- con_out holds its last captured value in IDLE; it changes only on capture, con_clr or reset.
- con_clr has priority over con_in and con_ack: con_out=0, con_valid=0, FSM=IDLE; no counter increment that cycle.
- taken_cnt increments by 1 on every capture with taken=1. It saturates at all-ones, with no wrap.
- cnt_clr zeroes taken_cnt. If cnt_clr and an increment occur together, cnt_clr wins and the result is 0.
- con_ack in IDLE is ignored.
- clear_n asserted mid-evaluation aborts it with no partial update. The first con_in after release behaves as from IDLE.
- X on bus_in is irrelevant when con_in=0.

Decomposition:
- Shared package holds:
  - condition-code localparams (CC_ZERO, CC_NONZERO, CC_POS, CC_NEG, CC_ALWAYS, CC_NEVER, CC_GTZ, CC_LEZ)
  - FSM state encoding (IDLE=1'b0, VALID=1'b1)
- One natural sub-module: cond_eval, a purely combinational cc + operand -> taken decoder, reusable by a future compare-branch unit.
- Top holds the FSM, flag register and counter.

Test Plan:
1. COND_W=2, ir[20:19]=00, bus_in=0, con_in pulse -> next cycle con_out=1, con_valid=1, taken_cnt=1; then con_ack -> con_valid=0 and con_out stays 1.
2. Sweep all four 2-bit codes with bus_in in {0x00000000, 0x00000005, 0x80000000}:
   - code 10 with 0 -> 1; code 10 with 0x80000000 -> 0
   - code 11 with 0x80000000 -> 1; code 01 with 0 -> 0
3. COND_W=3 build:
   - 110 with 0 -> 0; 111 with 0 -> 1
   - 100 -> always 1; 101 -> always 0 regardless of bus_in
4. In VALID, con_in and con_ack in the same cycle with a new result of 0 -> con_valid stays 1, con_out=0. Separately, con_clr with con_in -> con_out=0, con_valid=0, no count.
5. CNT_WIDTH=4: 17 taken captures -> taken_cnt saturates at 4'hF. cnt_clr coincident with a taken capture -> 0.
6. Assert clear_n low asynchronously between clock edges while in VALID -> outputs 0 immediately. After release, con_in with a taken condition -> normal 1-cycle capture.
